// File: rtl/conv_pkg.sv
// Shared types for the 3x3 convolution window sequencer:
// FSM state encoding and the nine tap row/column offsets.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    UPDATE = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Tap k = 3*(dr+1) + (dc+1)
  localparam int TAP_DR [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int TAP_DC [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

endpackage

// File: rtl/conv_tap_gen.sv
// Maps a (row, col) centre to nine tap read addresses and a border mask.
// Build option CONV_PAD_MASK_EN enables the border mask and centre substitution.
module conv_tap_gen #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0]   i_row,
  input  logic [ADDR_W-1:0]   i_col,
  output logic [9*ADDR_W-1:0] o_addr,
  output logic [8:0]          o_pad,
  output logic [ADDR_W-1:0]   o_centre
);
  import conv_pkg::*;

  always_comb begin
    o_centre = ADDR_W'(int'(i_row) * IMG_W + int'(i_col));
  end

  always_comb begin
    o_addr = '0;
    o_pad  = '0;
    for (int k = 0; k < 9; k++) begin
      int r;
      int c;
      logic [ADDR_W-1:0] a;
      r = int'(i_row) + TAP_DR[k];
      c = int'(i_col) + TAP_DC[k];
      a = ADDR_W'(r * IMG_W + c);
`ifdef CONV_PAD_MASK_EN
      // Out-of-image taps read the centre so no row wrap reaches the RAM
      if (r < 0 || r >= IMG_H || c < 0 || c >= IMG_W) begin
        o_pad[k] = 1'b1;
        a        = o_centre;
      end
`endif
      o_addr[k*ADDR_W +: ADDR_W] = a;
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// 3x3 window sequencer: walks the feature map, issues tap reads and writes.
// Border masking is selected at build time by CONV_PAD_MASK_EN.
module conv_window_sequencer #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_opcode,
  input  logic                i_stride2,
  input  logic                i_validRam,
  output logic [9*ADDR_W-1:0] o_addrRead,
  output logic [8:0]          o_padMask,
  output logic                o_startRam,
  output logic                o_selRamD0,
  output logic [ADDR_W-1:0]   o_addrWrite,
  output logic                o_wrEnable,
  output logic                o_busy,
  output logic                o_finish,
  output logic [ADDR_W-1:0]   o_localAddr
);
  import conv_pkg::*;

  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] H_A = ADDR_W'(IMG_H);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic              op_q, op_d;
  logic              s2_q, s2_d;

  logic [ADDR_W-1:0]   step;
  logic [ADDR_W-1:0]   waddr;
  logic [ADDR_W-1:0]   centre;
  logic [9*ADDR_W-1:0] taps;
  logic [8:0]          pad;
  logic                active;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      op_q    <= 1'b0;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      op_q    <= op_d;
      s2_q    <= s2_d;
    end
  end

  always_comb begin
    step = s2_q ? ADDR_W'(2) : ADDR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    op_d    = op_q;
    s2_d    = s2_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          op_d    = i_opcode;
          s2_d    = i_stride2;
          row_d   = '0;
          col_d   = '0;
          state_d = READ;
        end
      end
      READ:  state_d = WAIT;
      WAIT: begin
        if (i_validRam) state_d = WRITE;
      end
      WRITE: state_d = UPDATE;
      UPDATE: begin
        if (row_q == H_A - step && col_q == W_A - step) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          if (col_q + step >= W_A) begin
            col_d = '0;
            row_d = row_q + step;
          end else begin
            col_d = col_q + step;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stride 2 packs the output map densely at half width
  always_comb begin
    if (s2_q) waddr = (row_q >> 1) * (W_A >> 1) + (col_q >> 1);
    else      waddr = row_q * W_A + col_q;
  end

  conv_tap_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_tap_gen (
    .i_row    (row_q),
    .i_col    (col_q),
    .o_addr   (taps),
    .o_pad    (pad),
    .o_centre (centre)
  );

  always_comb begin
    active      = (state_q == READ) || (state_q == WAIT) ||
                  (state_q == WRITE) || (state_q == UPDATE);
    o_addrRead  = active ? taps : '0;
    o_padMask   = active ? pad : '0;
    o_addrWrite = active ? waddr : '0;
    o_localAddr = active ? centre : '0;
    o_startRam  = (state_q == READ);
    o_wrEnable  = (state_q == WRITE);
    o_finish    = (state_q == DONE);
    o_busy      = (state_q != IDLE);
    o_selRamD0  = (state_q == IDLE) ? (i_opcode & ~i_reset) : op_q;
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer on a 4x4 map.
// Table vectors for fixed pixels plus randomized runs against a reference model.
module tb_conv_window_sequencer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 4;
`ifdef CONV_PAD_MASK_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_start = 1'b0;
  logic          i_opcode = 1'b0;
  logic          i_stride2 = 1'b0;
  logic          i_validRam = 1'b0;
  logic [9*AW-1:0] o_addrRead;
  logic [8:0]    o_padMask;
  logic          o_startRam;
  logic          o_selRamD0;
  logic [AW-1:0] o_addrWrite;
  logic          o_wrEnable;
  logic          o_busy;
  logic          o_finish;
  logic [AW-1:0] o_localAddr;

  conv_window_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_opcode    (i_opcode),
    .i_stride2   (i_stride2),
    .i_validRam  (i_validRam),
    .o_addrRead  (o_addrRead),
    .o_padMask   (o_padMask),
    .o_startRam  (o_startRam),
    .o_selRamD0  (o_selRamD0),
    .o_addrWrite (o_addrWrite),
    .o_wrEnable  (o_wrEnable),
    .o_busy      (o_busy),
    .o_finish    (o_finish),
    .o_localAddr (o_localAddr)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit         s2;
    int         px;
    logic [3:0] centre;
    logic [3:0] waddr;
    logic [8:0] pad;
    logic [3:0] tap0;
    logic [3:0] tap1;
    logic [3:0] tap3;
  } vec_t;

  vec_t tv [8];

  logic [3:0]  obs_c [2][16];
  logic [3:0]  obs_w [2][16];
  logic [8:0]  obs_p [2][16];
  logic [35:0] obs_t [2][16];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Tap addresses from the raw coordinate arithmetic of the window
  function automatic logic [35:0] m_taps(input int r, input int c);
    logic [35:0] v;
    v = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr;
        int cc;
        int k;
        logic [3:0] a;
        rr = r + dr;
        cc = c + dc;
        k  = 3 * (dr + 1) + (dc + 1);
        a  = 4'((rr * W + cc) & 15);
        if (PAD && (rr < 0 || rr >= H || cc < 0 || cc >= W))
          a = 4'(r * W + c);
        v[k*4 +: 4] = a;
      end
    end
    return v;
  endfunction

  function automatic logic [8:0] m_pad(input int r, input int c);
    logic [8:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) begin
      int rr;
      int cc;
      rr = r + (k / 3) - 1;
      cc = c + (k % 3) - 1;
      if (PAD && (rr < 0 || rr >= H || cc < 0 || cc >= W)) v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic chk_idle(input string nm);
    chk(nm, 64'({o_addrRead, o_padMask, o_startRam, o_addrWrite,
                 o_wrEnable, o_busy, o_finish, o_localAddr}), 64'd0);
  endtask

  task automatic run(input bit s2, input bit op, input int dly,
                     input bit noise, input int abort_px);
    int step;
    int per;
    int npx;
    int n;
    int cyc;
    int t_sr;
    int t_wr;
    int d;
    int vcnt;
    int r;
    int c;
    bit done;
    bit clr;
    logic [35:0] cap;
    step = s2 ? 2 : 1;
    per  = W / step;
    npx  = (W / step) * (H / step);
    n = 0; cyc = 0; t_sr = 0; t_wr = -100; d = 0; vcnt = -1;
    done = 1'b0; clr = 1'b0; cap = '0;
    i_validRam = 1'b0;
    @(negedge i_clk);
    i_opcode = op;
    i_stride2 = s2;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_stride2 = ~s2;
    chk("start_latency", 64'(o_startRam), 64'd1);
    while (!done && cyc < 1000) begin
      if (clr) begin
        i_validRam = 1'b0;
        clr = 1'b0;
      end
      if (o_startRam) begin
        r = (n / per) * step;
        c = (n % per) * step;
        chk($sformatf("taps_px%0d", n), 64'(o_addrRead), 64'(m_taps(r, c)));
        chk($sformatf("pad_px%0d", n), 64'(o_padMask), 64'(m_pad(r, c)));
        chk($sformatf("centre_px%0d", n), 64'(o_localAddr), 64'(r * W + c));
        chk($sformatf("sel_px%0d", n), 64'({o_selRamD0, o_busy}),
            64'({op, 1'b1}));
        if (n > 0) chk("wr_to_read_gap", 64'(cyc - t_wr), 64'd2);
        if (n < 16) begin
          obs_c[s2][n] = o_localAddr;
          obs_w[s2][n] = o_addrWrite;
          obs_p[s2][n] = o_padMask;
          obs_t[s2][n] = o_addrRead;
        end
        t_sr = cyc;
        cap = o_addrRead;
        if (abort_px == n) begin
          @(negedge i_clk);
          i_opcode = 1'b1;
          i_reset = 1'b1;
          #1;
          chk("abort_outputs_zero", 64'({o_selRamD0, o_addrRead, o_padMask,
              o_startRam, o_addrWrite, o_wrEnable, o_busy, o_finish,
              o_localAddr}), 64'd0);
          @(negedge i_clk);
          i_opcode = 1'b0;
          i_reset = 1'b0;
          for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            chk("abort_quiet", 64'({o_wrEnable, o_finish, o_busy}), 64'd0);
          end
          return;
        end
        d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        vcnt = d;
      end
      if (vcnt == 0) i_validRam = 1'b1;
      if (vcnt >= 0) vcnt--;
      if (o_wrEnable) begin
        chk($sformatf("waddr_px%0d", n), 64'(o_addrWrite), 64'(n));
        chk($sformatf("taps_hold_px%0d", n), 64'(o_addrRead), 64'(cap));
        chk("read_to_wr_gap", 64'(cyc - t_sr), 64'(((d < 1) ? 1 : d) + 1));
        t_wr = cyc;
        n++;
        i_validRam = noise ? 1'($urandom) : 1'b0;
        clr = 1'b1;
      end
      if (o_finish) begin
        chk("finish_gap", 64'(cyc - t_wr), 64'd2);
        chk("write_count", 64'(n), 64'(npx));
        done = 1'b1;
        i_start = 1'b0;
        i_opcode = 1'b0;
      end else if (noise) begin
        i_opcode = 1'($urandom);
        i_start = 1'($urandom);
      end
      @(negedge i_clk);
      cyc++;
    end
    i_validRam = 1'b0;
    i_start = 1'b0;
    if (!done) chk("run_timeout", 64'd0, 64'd1);
    else chk_idle("idle_after_finish");
  endtask

  initial begin
    tv[0] = '{0, 0, 4'd0, 4'd0, PAD ? 9'h04F : 9'h0,
              PAD ? 4'd0 : 4'd11, PAD ? 4'd0 : 4'd12, PAD ? 4'd0 : 4'd15};
    tv[1] = '{0, 5, 4'd5, 4'd5, 9'h0, 4'd0, 4'd1, 4'd4};
    tv[2] = '{0, 15, 4'd15, 4'd15, PAD ? 9'h1E4 : 9'h0,
              4'd10, 4'd11, 4'd14};
    tv[3] = '{1, 0, 4'd0, 4'd0, PAD ? 9'h04F : 9'h0,
              PAD ? 4'd0 : 4'd11, PAD ? 4'd0 : 4'd12, PAD ? 4'd0 : 4'd15};
    tv[4] = '{1, 1, 4'd2, 4'd1, PAD ? 9'h007 : 9'h0,
              PAD ? 4'd2 : 4'd13, PAD ? 4'd2 : 4'd14, 4'd1};
    tv[5] = '{1, 2, 4'd8, 4'd2, PAD ? 9'h049 : 9'h0,
              PAD ? 4'd8 : 4'd3, 4'd4, PAD ? 4'd8 : 4'd7};
    tv[6] = '{1, 3, 4'd10, 4'd3, 9'h0, 4'd5, 4'd6, 4'd9};
    tv[7] = '{0, 10, 4'd10, 4'd10, 9'h0, 4'd5, 4'd6, 4'd9};

    #1;
    chk_idle("reset_outputs");
    chk("reset_sel", 64'(o_selRamD0), 64'd0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk_idle("post_reset_idle");

    run(1'b0, 1'b0, 2, 1'b0, -1);
    run(1'b1, 1'b1, 2, 1'b1, -1);

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tv%0d_centre", i),
          64'(obs_c[tv[i].s2][tv[i].px]), 64'(tv[i].centre));
      chk($sformatf("tv%0d_waddr", i),
          64'(obs_w[tv[i].s2][tv[i].px]), 64'(tv[i].waddr));
      chk($sformatf("tv%0d_pad", i),
          64'(obs_p[tv[i].s2][tv[i].px]), 64'(tv[i].pad));
      chk($sformatf("tv%0d_tap0", i),
          64'(obs_t[tv[i].s2][tv[i].px][3:0]), 64'(tv[i].tap0));
      chk($sformatf("tv%0d_tap1", i),
          64'(obs_t[tv[i].s2][tv[i].px][7:4]), 64'(tv[i].tap1));
      chk($sformatf("tv%0d_tap3", i),
          64'(obs_t[tv[i].s2][tv[i].px][15:12]), 64'(tv[i].tap3));
    end

    for (int i = 0; i < 6; i++) begin
      run(1'($urandom), 1'($urandom), -1, 1'b1, -1);
    end

    run(1'b0, 1'b1, 1, 1'b0, 5);
    run(1'b0, 1'b0, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Parametrised 3x3 convolution window sequencer that replaces the fixed 64x64 linear-address controller in the MobileNet datapath. It walks an IMG_W x IMG_H feature map in row/column coordinates, issues nine tap read addresses per output pixel to the source RAM banks, and handshakes with the RAM read engine. It then issues one write per output pixel to the destination bank. New behaviour over the fixed controller:
- selectable stride 1/2 with compacted write addressing
- latched opcode
- border padding mask for out-of-image taps

## Interface
Parameters:
- IMG_W, 64, feature-map width in pixels; even, ≥2
- IMG_H, 64, feature-map height in pixels; even, ≥2
- ADDR_W, 12, RAM address width; IMG_W*IMG_H ≤ 2^ADDR_W

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  reset; asynchronous, active-high
- i_start  in  1  start pulse; sampled in IDLE only
- i_opcode  in  1  source-bank select; latched at start
- i_stride2  in  1  0 = stride 1, 1 = stride 2; latched at start
- i_validRam  in  1  RAM engine has returned all nine taps
- o_addrRead  out  9*ADDR_W  tap k at bits [k*ADDR_W +: ADDR_W]
- o_padMask  out  9  bit k = 1 means tap k lies outside the image (read as zero)
- o_startRam  out  1  one-cycle pulse requesting a nine-tap read
- o_selRamD0  out  1  latched opcode
- o_addrWrite  out  ADDR_W  destination address of the current output pixel
- o_wrEnable  out  1  one-cycle write strobe
- o_busy  out  1  high in every state except IDLE
- o_finish  out  1  one-cycle pulse after the last write
- o_localAddr  out  ADDR_W  current centre address

## Operation
Tap k = 3*(dr+1) + (dc+1), with dr and dc each in {-1, 0, +1}.

Tap address: (row+dr)*IMG_W + (col+dc), computed at ADDR_W bits, modulo 2^ADDR_W.

Centre address: row*IMG_W + col.

STEP = 2 when stride 2 is latched, otherwise 1.

Write address: (row/STEP)*(IMG_W/STEP) + col/STEP.

State machine:
- IDLE
  - If i_start: latch i_opcode and i_stride2, clear row and col to 0, go to READ.
- READ
  - o_startRam = 1 for this one cycle; go to WAIT.
- WAIT
  - Hold all addresses.
  - Stay until i_validRam = 1, then go to WRITE. A valid arriving in the same cycle as entry is accepted.
- WRITE
  - o_wrEnable = 1 for this one cycle; go to UPDATE.
- UPDATE
  - col += STEP.
  - If col + STEP ≥ IMG_W: col = 0 and row += STEP.
  - If this was the last pixel (row = IMG_H-STEP and col = IMG_W-STEP): go to DONE, otherwise go to READ.
- DONE
  - o_finish = 1; go to IDLE.

Behaviour rules:
- i_start is ignored whenever o_busy = 1.
- i_validRam is ignored outside WAIT.
- In IDLE and DONE, every address output and o_padMask is 0.

## Timing
- Reset (asynchronous, active-high):
  - state goes to IDLE; row, col, latched opcode and latched stride go to 0.
  - All outputs are 0 while reset is asserted and after it releases.
- Reset mid-run aborts immediately. No o_finish and no o_wrEnable follow.
- Per-pixel cycles: READ 1 + WAIT (≥1) + WRITE 1 + UPDATE 1, so at least 4 cycles per pixel.
- Start-to-first-o_startRam latency: 1 cycle.
- o_finish is asserted exactly 2 cycles after the last o_wrEnable.
- All outputs are registered state or combinational from registered state. No input-to-output combinational path, except that o_selRamD0 in IDLE follows i_opcode.

## Configuration
CONV_PAD_MASK_EN:
- Defined:
  - o_padMask flags every tap with row+dr or col+dc outside the image.
  - Each flagged tap's address is replaced by the centre address, so no row wrap occurs.
- Undefined:
  - o_padMask is tied to 0.
  - Tap addresses are the raw modulo-2^ADDR_W values, matching the legacy controller.

## Structure
- Shared package `conv_pkg`:
  - state encoding localparams (IDLE=0, READ=1, WAIT=2, WRITE=3, UPDATE=4, DONE=5)
  - tap offset constants TAP_DR[9] and TAP_DC[9]
- One sub-module, `conv_tap_gen`:
  - combinational; maps (row, col) to nine tap addresses plus o_padMask
  - holds the CONV_PAD_MASK_EN conditional
- Top level holds the FSM, the counters and the write-address computation.

## Test plan
All scenarios use IMG_W = IMG_H = 4 and ADDR_W = 4.

- Stride 1, macro defined, pixel (0,0):
  - taps 0,1,2,3,6 masked, o_padMask = 9'h04F
  - centre = 0; o_addrWrite = 0.
- Stride 1, pixel (1,1):
  - o_addrRead taps = 0,1,2,4,5,6,8,9,10; o_padMask = 0; o_addrWrite = 5.
- Stride 1, full run, i_validRam asserted 2 cycles after each o_startRam:
  - 16 o_wrEnable pulses at addresses 0..15
  - one o_finish pulse 2 cycles after the last write; o_busy then returns to 0.
- Stride 2 run:
  - 4 writes at o_addrWrite 0,1,2,3 with centres 0,2,8,10
  - o_selRamD0 holds the latched opcode even if i_opcode toggles mid-run.
- Macro undefined, pixel (0,0):
  - tap0 = 11, tap1 = 12, tap3 = 15; o_padMask = 0.
- Assert i_reset in WAIT at pixel 5:
  - all outputs read 0 in the same cycle; no o_finish follows.
  - A later i_start restarts at pixel (0,0).
